// File: rtl/cache_pkg.sv
// Shared definitions for the cache/memory arbiter.
//   arb_state_t   : arbiter FSM states (IDLE, ISSUE, WAIT)
//   REQ_I, REQ_D  : requester ids (I-cache refill path, D-cache path)
//   line_offset_w : byte-offset width of a cache line for a given burst length
//   LINE_OFFSET_W : line offset width for the default 4-word line
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // log2(words per line) + 2 byte-offset bits inside a word
    function automatic int line_offset_w(input int burst_len);
        return $clog2(burst_len) + 2;
    endfunction

    localparam int LINE_OFFSET_W = line_offset_w(4);

endpackage

// File: rtl/arb_grant.sv
// Two-input grant logic for the cache/memory arbiter.
// Build option: ARB_RR_EN selects round-robin arbitration; otherwise the
// D requester always wins over I and no pointer state exists.
// Ports:
//   clk, reset    : clock / async active-low reset (ARB_RR_EN builds only)
//   done, done_id : a transaction completed this cycle, and who it served
//                   (ARB_RR_EN builds only)
//   i_valid       : I-cache request pending
//   d_valid       : D-cache request pending
//   grant_valid   : at least one request pending
//   grant_id      : winning requester (REQ_I / REQ_D)
module arb_grant
    import cache_pkg::*;
(
`ifdef ARB_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic done,
    input  logic done_id,
`endif
    input  logic i_valid,
    input  logic d_valid,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = i_valid | d_valid;

`ifdef ARB_RR_EN
    // Requester that wins a tie; flips to whoever was not just served.
    logic favour;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            favour <= REQ_I;
        end else if (done) begin
            favour <= ~done_id;
        end
    end

    always_comb begin
        if (i_valid && d_valid) begin
            grant_id = favour;
        end else begin
            grant_id = d_valid ? REQ_D : REQ_I;
        end
    end
`else
    assign grant_id = d_valid ? REQ_D : REQ_I;
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one external memory port between the I-cache refill path and the
// D-cache miss/write path. One transaction at a time: reads become a
// BURST_LEN-word line refill issued critical-word-first with wrap inside the
// line, D writes are a single write-through beat. Only one memory command is
// ever outstanding.
// Build option: ARB_RR_EN enables round-robin grant (default: D over I).
// Ports:
//   clk, reset                 : clock, async active-low reset
//   i_req_valid/addr/ready     : I-cache refill request
//   i_resp_valid/data/addr/last: I refill beats
//   d_req_valid/we/addr/wdata/ready : D-cache request (we=1 single write)
//   d_resp_valid/data/addr/last: D beats (write ack has data 0, last 1)
//   mem_req_valid/ready/addr/we/wdata : memory command channel
//   mem_resp_valid/data        : memory read data / write ack, in order
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_data,
    output logic [ADDR_W-1:0] i_resp_addr,
    output logic              i_resp_last,

    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,
    output logic [ADDR_W-1:0] d_resp_addr,
    output logic              d_resp_last,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);

    localparam int OFF_W  = line_offset_w(BURST_LEN);
    localparam int WORD_W = OFF_W - 2;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [WORD_W-1:0] beat;
    logic [WORD_W-1:0] beat_next;
    logic              cur_id;
    logic              cur_we;

    logic [DATA_W-1:0] cur_wdata;
    logic [ADDR_W-1:0] line_base;
    logic [WORD_W-1:0] start_word;

    logic              grant_valid;
    logic              grant_id;
    logic              accept;
    logic              last_beat;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] beat_addr;

`ifdef ARB_RR_EN
    logic txn_done;
    assign txn_done = (state == WAIT) && mem_resp_valid && last_beat;
`endif

    arb_grant u_grant (
`ifdef ARB_RR_EN
        .clk         (clk),
        .reset       (reset),
        .done        (txn_done),
        .done_id     (cur_id),
`endif
        .i_valid     (i_req_valid),
        .d_valid     (d_req_valid),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Ready is gated by reset so no requester sees an acceptance while the
    // arbiter is held in reset.
    assign accept   = reset && (state == IDLE) && grant_valid;
    assign req_addr = (grant_id == REQ_D) ? d_req_addr : i_req_addr;

    // Word index wraps naturally modulo BURST_LEN (power of two).
    assign word      = start_word + beat;
    assign beat_addr = line_base | {{(ADDR_W - OFF_W){1'b0}}, word, 2'b00};
    assign last_beat = cur_we || (beat == LAST_BEAT);

    // Control state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            beat   <= '0;
            cur_id <= REQ_I;
            cur_we <= 1'b0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
            if (accept) begin
                cur_id <= grant_id;
                cur_we <= (grant_id == REQ_D) && d_req_we;
            end
        end
    end

    // Transaction payload, only meaningful once a grant has been taken
    always_ff @(posedge clk) begin
        if (accept) begin
            cur_wdata  <= d_req_wdata;
            line_base  <= req_addr & ~LINE_MASK;
            start_word <= req_addr[OFF_W-1:2];
        end
    end

    always_comb begin
        state_next    = state;
        beat_next     = beat;
        i_req_ready   = 1'b0;
        d_req_ready   = 1'b0;
        i_resp_valid  = 1'b0;
        i_resp_data   = '0;
        i_resp_addr   = '0;
        i_resp_last   = 1'b0;
        d_resp_valid  = 1'b0;
        d_resp_data   = '0;
        d_resp_addr   = '0;
        d_resp_last   = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_we    = 1'b0;
        mem_req_wdata = '0;

        case (state)
            IDLE: begin
                if (accept) begin
                    i_req_ready = (grant_id == REQ_I);
                    d_req_ready = (grant_id == REQ_D);
                    beat_next   = '0;
                    state_next  = ISSUE;
                end
            end

            ISSUE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = beat_addr;
                mem_req_we    = cur_we;
                mem_req_wdata = cur_we ? cur_wdata : '0;
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end

            WAIT: begin
                if (mem_resp_valid) begin
                    if (cur_id == REQ_D) begin
                        d_resp_valid = 1'b1;
                        d_resp_data  = cur_we ? '0 : mem_resp_data;
                        d_resp_addr  = beat_addr;
                        d_resp_last  = last_beat;
                    end else begin
                        i_resp_valid = 1'b1;
                        i_resp_data  = mem_resp_data;
                        i_resp_addr  = beat_addr;
                        i_resp_last  = last_beat;
                    end
                    if (last_beat) begin
                        beat_next  = '0;
                        state_next = IDLE;
                    end else begin
                        beat_next  = beat + WORD_W'(1);
                        state_next = ISSUE;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sequences and shares the single external memory port between the I-cache refill path and the D-cache miss/write path of the RV32ICMFA core.
- Accepts one request at a time. Read requests become a BURST_LEN-word line refill, issued critical-word-first with wrap inside the line; D-side writes are single-beat write-through.
- Returns response beats to the granted requester, tagged with a last flag, so each cache fills its line RAM directly.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data word width
- BURST_LEN, 4, words per cache line (power of 2, at least 2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- i_req_valid  in  1  I-cache refill request
- i_req_addr  in  ADDR_W  miss PC (word aligned)
- i_req_ready  out  1  I request accepted this cycle
- i_resp_valid  out  1  I refill beat valid
- i_resp_data  out  DATA_W  refill word
- i_resp_addr  out  ADDR_W  address of this beat
- i_resp_last  out  1  final beat of line
- d_req_valid  in  1  D-cache request
- d_req_we  in  1  1 = single-word write, 0 = line refill
- d_req_addr  in  ADDR_W  word-aligned address
- d_req_wdata  in  DATA_W  write data
- d_req_ready  out  1  D request accepted this cycle
- d_resp_valid  out  1  D beat valid (write ack when we)
- d_resp_data  out  DATA_W  read word (0 for write ack)
- d_resp_addr  out  ADDR_W  address of this beat
- d_resp_last  out  1  final beat
- mem_req_valid  out  1  memory command valid
- mem_req_ready  in  1  memory accepts command
- mem_req_addr  out  ADDR_W  command address
- mem_req_we  out  1  write command
- mem_req_wdata  out  DATA_W  write data
- mem_resp_valid  in  1  memory data/ack, one per accepted command, in order
- mem_resp_data  in  DATA_W  read data

Behaviour:
- Reset (async, active-low):
  - FSM goes to IDLE, beat counter 0, round-robin pointer favours I.
  - Every output is 0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - *_req_ready is combinational and high only in IDLE, for the granted requester.
  - Grant is fixed priority: D over I.
  - On grant, latch requester id, we, wdata, start address, and line base = addr with the low log2(BURST_LEN)+2 bits cleared. Go to ISSUE.
- ISSUE:
  - mem_req_valid=1 with mem_req_addr = base + ((start_word + beat) mod BURST_LEN)*4.
  - mem_req_valid is first driven the cycle after acceptance and held stable until mem_req_ready.
  - On handshake, go to WAIT.
- WAIT:
  - On mem_resp_valid, pulse the granted *_resp_valid for 1 cycle, in the same cycle, with data and address.
  - *_resp_last=1 when beat == BURST_LEN-1, or on any write.
  - If last, go to IDLE; else beat+1 and go to ISSUE.
- Only one command is outstanding at a time.
- Wrap-around: the beat address wraps inside the line. Start word 3 of 4 gives order 3, 0, 1, 2.
- Write: one command with mem_req_we=1. The ack beat gives d_resp_valid=1, d_resp_data=0, d_resp_last=1.
- Non-granted requester:
  - ready and resp stay 0.
  - Its request stays pending. The requester must hold valid and addr until it sees ready.
- Simultaneous I and D requests in IDLE: D is granted. I is served on the next IDLE cycle.
- Back-to-back:
  - A return to IDLE costs 1 cycle.
  - A new grant is possible in the cycle after the last beat.
  - Minimum read latency from accept to first beat: 2 cycles plus memory latency.
- mem_resp_valid in IDLE or ISSUE is ignored (protocol error, must not change state).
- Reset asserted mid-burst:
  - Immediate abort; no further resp beats.
  - The requester must reissue after reset.

Optional Feature:
- ARB_RR_EN defined:
  - Round-robin grant. The pointer toggles to the other requester after each completed transaction.
  - When both are valid, the one not served last wins.
- ARB_RR_EN undefined: fixed priority, D over I. The pointer logic is absent.

Decomposition:
- Shared package cache_pkg holds:
  - the arb_state_t enum {IDLE, ISSUE, WAIT}
  - the requester id constants REQ_I=0 and REQ_D=1
  - LINE_OFFSET_W = log2(BURST_LEN)+2
- One sub-module is natural: arb_grant, the 2-input priority / round-robin grant logic (combinational grant plus pointer register).

Test Plan:
- I read 0x0000_100C, memory latency 2, BURST_LEN 4:
  - mem addrs 0x100C, 0x1000, 0x1004, 0x1008 in that order.
  - 4 i_resp beats; last on the 0x1008 beat.
  - FSM back in IDLE one cycle later.
- I and D requests in the same cycle (D read 0x2000):
  - d_req_ready=1 and i_req_ready=0.
  - D burst 0x2000 to 0x200C completes first.
  - I is granted in the IDLE cycle after d_resp_last.
  - With ARB_RR_EN, a second simultaneous pair is granted to I.
- D write 0x3004 with data 0xDEADBEEF:
  - single mem command, we=1.
  - On ack: d_resp_valid=1, d_resp_last=1, d_resp_data=0.
  - No I beats.
- mem_req_ready held low 5 cycles during ISSUE:
  - mem_req_addr and mem_req_valid stay stable.
  - No resp beats.
  - Progress resumes on ready.
- Spurious mem_resp_valid in IDLE: no *_resp_valid and no state change.
- Reset pulled low during beat 2 of an I refill:
  - all outputs 0 within the same cycle.
  - No further beats.
  - After release, a new I request restarts from beat 0.
